hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Parametrised successor of the single-cycle load-use stall detector.
- Per-register scoreboard of pending results; latency classes ALU / load / multi-cycle MDU; MDU structural-hazard stall; WAW stall; branch-flush arbitration; saturating stall-cycle counter.
- Sits beside the ID stage: consumes decoded ID fields plus the EX-stage branch-resolve signal; drives pipeline hold, bubble and flush controls.

Parameters:
- NREG, 32, architectural register count; register 0 is hard-wired zero.
- AW, 5, register index width, equal to $clog2(NREG).
- LOAD_LAT, 1, stall cycles a consumer immediately following a load needs with forwarding; range 0..7.
- MDU_LAT, 4, cycles until an MDU result is forwardable; also the MDU occupancy; range 1..15.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register indices.
- id_uses_rs, id_uses_rt  in  1  the corresponding source is actually read.
- id_rd  in  AW  destination index.
- id_writes  in  1  instruction writes id_rd.
- id_is_load  in  1  latency class is load.
- id_is_mdu  in  1  latency class is MDU; never high together with id_is_load.
- ex_flush  in  1  branch taken/redirect resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  inject NOP into ID/EX.
- flush_id  out  1  squash IF/ID contents.
- issue  out  1  ID instruction advances this cycle.
- stall_cycles  out  PERF_W  saturating count of stall cycles.

Behaviour:
- State: cnt[r] (width CW = $clog2(max(LOAD_LAT,MDU_LAT)+1)) per register r = 1..NREG-1; mdu_busy down-counter (width CW); stall_cycles.
- Reset (rst_n = 0 at a clk edge): all cnt = 0, mdu_busy = 0, stall_cycles = 0.
- While rst_n = 0, stall, bubble, flush_id and issue are forced to 0.
- RAW hazard = (id_uses_rs && id_rs != 0 && cnt[id_rs] != 0) || (same test for rt).
- WAW hazard = id_writes && id_rd != 0 && cnt[id_rd] != 0.
- Structural hazard = id_is_mdu && mdu_busy != 0.
- haz = id_valid && (RAW || WAW || structural).
- Outputs are combinational from registered state plus ID inputs, same cycle:
  - flush_id = ex_flush.
  - stall = haz && !ex_flush. Flush wins; a wrong-path instruction never stalls.
  - bubble = stall || ex_flush.
  - issue = id_valid && !stall && !ex_flush.
- Clocked update, each cycle:
  - Every nonzero cnt decrements by 1; mdu_busy decrements if nonzero.
  - Then, if issue && id_writes && id_rd != 0: cnt[id_rd] <= LOAD_LAT for a load, MDU_LAT for MDU, else 0.
  - If issue && id_is_mdu: mdu_busy <= MDU_LAT, including MDU ops with id_writes = 0.
  - Issue assignment overrides the decrement for the same index.
- Latency:
  - A consumer directly after a load stalls LOAD_LAT cycles.
  - A consumer directly after an MDU op stalls MDU_LAT cycles.
  - With LOAD_LAT = 0, loads never stall.
- Writes to r0 are never tracked; r0 sources never stall.
- Flush squashes only the ID instruction. Older issued entries keep counting; no rollback.
- stall_cycles increments when stall = 1 and saturates at all-ones; flush cycles are not counted.
- Reset mid-stall: next cycle all hazards clear; a held instruction issues if id_valid.

Decomposition:
- Package hazard_pkg: latency-class enum (LAT_ALU, LAT_LOAD, LAT_MDU); CW computation function; REG0 constant.
- Sub-module hazard_sb_entry: one per-register loadable down-counter with busy output, instantiated NREG-1 times by generate.

Test Plan:
- Load r5 issues, next instruction reads r5 (LOAD_LAT = 1) -> stall = 1 and bubble = 1 for exactly 1 cycle, then issue = 1; stall_cycles = 1.
- MDU writes r8, next instruction reads r8 (MDU_LAT = 4) -> stall for 4 consecutive cycles, issue on the 5th; stall_cycles = 4.
- Two back-to-back MDU ops with independent registers -> second stalls 4 cycles (structural); independent ALU ops in between issue with no stall.
- Load writes r0, next instruction reads r0 -> no stall; issue = 1 in the next cycle.
- Load-use hazard present in the same cycle as ex_flush = 1 -> stall = 0, flush_id = 1, bubble = 1, issue = 0; stall_cycles unchanged.
- MDU to r3, then rst_n = 0 for 1 cycle, then a read of r3 -> no stall after reset; all outputs 0 during reset; stall_cycles = 0.
- Force 2^PERF_W + 3 stall cycles with PERF_W = 4 -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MDU  = 2'd2
    } lat_class_e;

    localparam int REG0 = 0;

    // Counter width wide enough to hold the longest latency class.
    function automatic int calc_cw(input int load_lat, input int mdu_lat);
        int max_lat;
        max_lat = (load_lat > mdu_lat) ? load_lat : mdu_lat;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: loadable down-counter, busy while nonzero.
module hazard_sb_entry #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt;

    // A fresh issue to this register overrides the running countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard scoreboard: RAW/WAW/MDU-structural stalls with
// flush arbitration and a saturating stall-cycle counter.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_writes,
    input  logic              id_is_load,
    input  logic              id_is_mdu,
    input  logic              ex_flush,
    output logic              stall,
    output logic              bubble,
    output logic              flush_id,
    output logic              issue,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CW = calc_cw(LOAD_LAT, MDU_LAT);

    logic [NREG-1:0] busy;
    logic [CW-1:0]   mdu_busy;
    lat_class_e      id_class;
    logic [CW-1:0]   wr_lat;
    logic            raw_haz;
    logic            waw_haz;
    logic            str_haz;
    logic            haz;

    // Latency class of the ID instruction selects the scoreboard load value.
    always_comb begin
        id_class = LAT_ALU;
        if (id_is_mdu) begin
            id_class = LAT_MDU;
        end else if (id_is_load) begin
            id_class = LAT_LOAD;
        end
        case (id_class)
            LAT_LOAD: wr_lat = CW'(LOAD_LAT);
            LAT_MDU:  wr_lat = CW'(MDU_LAT);
            default:  wr_lat = '0;
        endcase
    end

    // r0 is never tracked.
    assign busy[REG0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_entry
            hazard_sb_entry #(.CW(CW)) u_entry (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (issue && id_writes && (id_rd == AW'(r))),
                .load_val (wr_lat),
                .busy     (busy[r])
            );
        end
    endgenerate

    // Hazard detection from registered scoreboard state and ID fields.
    always_comb begin
        raw_haz = (id_uses_rs && (id_rs != AW'(REG0)) && busy[id_rs]) ||
                  (id_uses_rt && (id_rt != AW'(REG0)) && busy[id_rt]);
        waw_haz = id_writes && (id_rd != AW'(REG0)) && busy[id_rd];
        str_haz = id_is_mdu && (mdu_busy != '0);
        haz     = id_valid && (raw_haz || waw_haz || str_haz);
    end

    // Flush wins over stall; everything is quiet while in reset.
    assign flush_id = rst_n && ex_flush;
    assign stall    = rst_n && haz && !ex_flush;
    assign bubble   = stall || flush_id;
    assign issue    = rst_n && id_valid && !stall && !ex_flush;

    // MDU occupancy counter; MDU ops without a destination still occupy it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdu_busy <= '0;
        end else if (issue && id_is_mdu) begin
            mdu_busy <= CW'(MDU_LAT);
        end else if (mdu_busy != '0) begin
            mdu_busy <= mdu_busy - 1'b1;
        end
    end

    // Saturating count of stall cycles; flush cycles are not stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

    localparam int LOAD_LAT = 1;
    localparam int MDU_LAT  = 4;

    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int rd;
        bit wr;
        bit ld;
        bit md;
    } ins_t;

    typedef struct {
        bit stall;
        bit bubble;
        bit flush_id;
        bit issue;
        int sc16;
        int sc4;
        int cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt, id_writes, id_is_load, id_is_mdu;
    logic        ex_flush;
    logic        stall, bubble, flush_id, issue;
    logic [15:0] stall_cycles;
    logic        stall_p4, bubble_p4, flush_id_p4, issue_p4;
    logic [3:0]  stall_cycles_p4;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference model: per-register cycle number at which the value is usable.
    int ready_at[32];
    int mdu_free_at;
    int cyc;
    int sc16, sc4;

    hazard_scoreboard_unit #(
        .NREG(32), .AW(5), .LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT), .PERF_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_writes(id_writes), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .ex_flush(ex_flush), .stall(stall), .bubble(bubble), .flush_id(flush_id),
        .issue(issue), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard_unit #(
        .NREG(32), .AW(5), .LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT), .PERF_W(4)
    ) u_dut_p4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_writes(id_writes), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .ex_flush(ex_flush), .stall(stall_p4), .bubble(bubble_p4), .flush_id(flush_id_p4),
        .issue(issue_p4), .stall_cycles(stall_cycles_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int c, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, act, want);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",         e.cyc, int'(stall),           int'(e.stall));
                chk("bubble",        e.cyc, int'(bubble),          int'(e.bubble));
                chk("flush_id",      e.cyc, int'(flush_id),        int'(e.flush_id));
                chk("issue",         e.cyc, int'(issue),           int'(e.issue));
                chk("stall_cycles",  e.cyc, int'(stall_cycles),    e.sc16);
                chk("stall_cyc_p4",  e.cyc, int'(stall_cycles_p4), e.sc4);
                chk("stall_p4",      e.cyc, int'(stall_p4),        int'(e.stall));
                chk("issue_p4",      e.cyc, int'(issue_p4),        int'(e.issue));
            end
        end
    end

    function automatic bit pending(input int r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    // One clock: drive inputs, push model expectation, advance model.
    task automatic step(input bit rst, input bit flush, input ins_t i, output bit iss);
        exp_t e;
        bit   haz;
        int   lat;
        @(posedge clk);
        #1;
        rst_n      = rst;
        ex_flush   = flush;
        id_valid   = i.v;
        id_rs      = 5'(i.rs);
        id_rt      = 5'(i.rt);
        id_uses_rs = i.urs;
        id_uses_rt = i.urt;
        id_rd      = 5'(i.rd);
        id_writes  = i.wr;
        id_is_load = i.ld;
        id_is_mdu  = i.md;

        haz = i.v && ((i.urs && pending(i.rs)) || (i.urt && pending(i.rt)) ||
                      (i.wr && pending(i.rd)) || (i.md && mdu_free_at > cyc));
        e.stall    = rst && haz && !flush;
        e.flush_id = rst && flush;
        e.bubble   = e.stall || e.flush_id;
        e.issue    = rst && i.v && !e.stall && !flush;
        e.sc16     = sc16;
        e.sc4      = sc4;
        e.cyc      = cyc;
        exp_q.push_back(e);
        iss = e.issue;

        if (!rst) begin
            foreach (ready_at[k]) ready_at[k] = 0;
            mdu_free_at = 0;
            sc16 = 0;
            sc4  = 0;
        end else begin
            if (e.stall) begin
                if (sc16 < 65535) sc16++;
                if (sc4 < 15) sc4++;
            end
            if (e.issue) begin
                lat = i.ld ? LOAD_LAT : (i.md ? MDU_LAT : 0);
                if (i.wr && i.rd != 0) ready_at[i.rd] = cyc + 1 + lat;
                if (i.md) mdu_free_at = cyc + 1 + MDU_LAT;
            end
        end
        cyc++;
    endtask

    // Hold an instruction in ID until it issues (bounded).
    task automatic send(input ins_t i);
        bit iss;
        int n;
        n = 0;
        iss = 0;
        while (!iss && n < 40) begin
            step(1'b1, 1'b0, i, iss);
            n++;
        end
        total++;
        if (!iss) begin
            bad++;
            $display("FAIL send_bound cyc=%0d got=not_issued want=issued", cyc);
        end
    endtask

    function automatic ins_t mk(input int rd, input int rs, input int rt,
                                input bit wr, input bit ld, input bit md);
        ins_t i;
        i.v = 1; i.rd = rd; i.rs = rs; i.rt = rt;
        i.urs = 1; i.urt = (rt >= 0); if (rt < 0) i.rt = 0;
        i.wr = wr; i.ld = ld; i.md = md;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        int k;
        i.v   = ($urandom_range(0, 7) != 0);
        i.rs  = $urandom_range(0, 7);
        i.rt  = $urandom_range(0, 7);
        i.rd  = $urandom_range(0, 7);
        i.urs = $urandom_range(0, 1);
        i.urt = $urandom_range(0, 1);
        i.wr  = ($urandom_range(0, 3) != 0);
        k     = $urandom_range(0, 3);
        i.ld  = (k == 1);
        i.md  = (k == 2);
        return i;
    endfunction

    initial begin
        ins_t nop, cur;
        bit   iss, rst, fl;
        nop = '{default: 0};
        foreach (ready_at[k]) ready_at[k] = 0;
        mdu_free_at = 0; cyc = 0; sc16 = 0; sc4 = 0;
        rst_n = 0; ex_flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_writes = 0; id_is_load = 0; id_is_mdu = 0;

        step(1'b0, 1'b0, nop, iss);
        step(1'b0, 1'b1, mk(5, 1, 2, 1, 0, 0), iss);
        step(1'b1, 1'b0, nop, iss);

        // load-use
        send(mk(5, 1, -1, 1, 1, 0));
        send(mk(6, 5, 2, 1, 0, 0));
        // MDU-use
        send(mk(8, 1, 2, 1, 0, 1));
        send(mk(9, 8, -1, 1, 0, 0));
        // structural: MDU, ALU, MDU, then back-to-back MDU
        send(mk(10, 1, 2, 1, 0, 1));
        send(mk(11, 1, 2, 1, 0, 0));
        send(mk(12, 3, 4, 1, 0, 1));
        send(mk(13, 1, 2, 1, 0, 1));
        send(mk(14, 3, 4, 0, 0, 1));
        send(mk(15, 1, 2, 1, 0, 1));
        // load to r0, reader of r0
        send(mk(0, 1, -1, 1, 1, 0));
        send(mk(7, 0, 0, 1, 0, 0));
        // hazard coincident with flush
        send(mk(5, 1, -1, 1, 1, 0));
        step(1'b1, 1'b1, mk(6, 5, 5, 1, 0, 0), iss);
        send(mk(6, 5, 5, 1, 0, 0));
        // WAW against a pending MDU
        send(mk(9, 1, 2, 1, 0, 1));
        send(mk(9, 1, 2, 1, 0, 0));
        // saturation on the 4-bit counter
        for (int k = 0; k < 5; k++) begin
            send(mk(8, 1, 2, 1, 0, 1));
            send(mk(9, 8, -1, 1, 0, 0));
        end
        // reset mid-stall
        send(mk(3, 1, 2, 1, 0, 1));
        step(1'b1, 1'b0, mk(4, 3, -1, 1, 0, 0), iss);
        step(1'b0, 1'b0, mk(4, 3, -1, 1, 0, 0), iss);
        send(mk(4, 3, -1, 1, 0, 0));

        // randomized traffic: held instruction stays until issued or flushed
        cur = rnd_ins();
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            step(rst, fl, cur, iss);
            if (iss || fl || !rst || !cur.v) cur = rnd_ins();
        end

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
